// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: stall/flush enables and registered EX forwarding selects.
// Optional perf counters (lu_cnt, fl_cnt) are built only with HAZARD_PERF_EN defined.
module hazard_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [5:0]  LU_CODE = 6'b111111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       hz_type,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rt_e,
  input  logic             branch_taken_e,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] fl_cnt
);

  typedef enum logic {RUN, LU_STALL} state_t;

  state_t     state, stateNext;
  logic [1:0] mask, maskNext;
  logic [1:0] fwdANext, fwdBNext;
  logic       luDetect, flushEvt;

  always_comb begin
    stateNext   = state;
    maskNext    = mask;
    fwdANext    = fwd_a_e;
    fwdBNext    = fwd_b_e;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    luDetect    = 1'b0;
    flushEvt    = 1'b0;
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (!mem_busy) begin
      unique case (state)
        RUN: begin
          if (branch_taken_e) begin
            pc_en       = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            fwdANext    = '0;
            fwdBNext    = '0;
            flushEvt    = 1'b1;
          end else if (hz_type == LU_CODE) begin
            idex_bubble = 1'b1;
            fwdANext    = '0;
            fwdBNext    = '0;
            // $zero is never a real dependency, so a zero load target sets no bit
            maskNext    = {(rs_d == rt_e) && (rt_e != '0),
                           (rt_d == rt_e) && (rt_e != '0)};
            stateNext   = LU_STALL;
            luDetect    = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            fwdANext = hz_type[3:2];
            fwdBNext = hz_type[1:0];
          end
        end
        LU_STALL: begin
          pc_en     = 1'b1;
          ifid_en   = 1'b1;
          fwdANext  = mask[1] ? 2'b10 : 2'b00;
          fwdBNext  = mask[0] ? 2'b10 : 2'b00;
          maskNext  = '0;
          stateNext = RUN;
        end
        default: stateNext = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      mask    <= '0;
      fwd_a_e <= '0;
      fwd_b_e <= '0;
    end else begin
      state   <= stateNext;
      mask    <= maskNext;
      fwd_a_e <= fwdANext;
      fwd_b_e <= fwdBNext;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] luCnt, flCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luCnt <= '0;
      flCnt <= '0;
    end else begin
      if (luDetect && (luCnt != '1)) luCnt <= luCnt + 1'b1;
      if (flushEvt && (flCnt != '1)) flCnt <= flCnt + 1'b1;
    end
  end

  assign lu_cnt = luCnt;
  assign fl_cnt = flCnt;
`else
  assign lu_cnt = '0;
  assign fl_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] hz_type = '0;
  logic [4:0] rs_d = '0, rt_d = '0, rt_e = '0;
  logic       branch_taken_e = 1'b0, mem_busy = 1'b0;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [3:0] lu_cnt, fl_cnt;

  int nChecks = 0;
  int nPass = 0;

  hazard_ctrl #(.CNT_W(4), .LU_CODE(6'b111111)) dut (
    .clk(clk), .rst_n(rst_n), .hz_type(hz_type), .rs_d(rs_d), .rt_d(rt_d),
    .rt_e(rt_e), .branch_taken_e(branch_taken_e), .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .lu_cnt(lu_cnt), .fl_cnt(fl_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    hz_type = '0; rs_d = '0; rt_d = '0; rt_e = '0;
    branch_taken_e = 1'b0; mem_busy = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    hz_type = 6'b000101;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    nChecks++; if (pc_en !== 1'b0) $display("FAIL rst_pc_en got %b exp 0", pc_en); else nPass++;
    nChecks++; if (ifid_en !== 1'b0) $display("FAIL rst_ifid_en got %b exp 0", ifid_en); else nPass++;
    nChecks++; if (ifid_flush !== 1'b1) $display("FAIL rst_flush got %b exp 1", ifid_flush); else nPass++;
    nChecks++; if (idex_bubble !== 1'b1) $display("FAIL rst_bubble got %b exp 1", idex_bubble); else nPass++;
    nChecks++; if ({fwd_a_e, fwd_b_e} !== 4'b0000) $display("FAIL rst_fwd got %b exp 0000", {fwd_a_e, fwd_b_e}); else nPass++;
    nChecks++; if ({lu_cnt, fl_cnt} !== 8'h00) $display("FAIL rst_cnt got %h exp 00", {lu_cnt, fl_cnt}); else nPass++;
    hz_type = '0;
    rst_n = 1'b1;
    #1;
    nChecks++; if ({pc_en, ifid_en} !== 2'b11) $display("FAIL rst_release_en got %b exp 11", {pc_en, ifid_en}); else nPass++;
  endtask

  task automatic test_forwarding();
    apply_reset();
    hz_type = 6'b000101;
    cyc();
    nChecks++; if ({fwd_a_e, fwd_b_e} !== 4'b0101) $display("FAIL fwd_0101 got %b exp 0101", {fwd_a_e, fwd_b_e}); else nPass++;
    hz_type = 6'b000111;
    cyc();
    nChecks++; if ({fwd_a_e, fwd_b_e} !== 4'b0111) $display("FAIL fwd_0111 got %b exp 0111", {fwd_a_e, fwd_b_e}); else nPass++;
  endtask

  task automatic test_load_use();
    apply_reset();
    hz_type = 6'b111111; rs_d = 5'd5; rt_d = 5'd7; rt_e = 5'd5;
    #1;
    nChecks++; if ({pc_en, ifid_en, idex_bubble} !== 3'b001) $display("FAIL lu_c0_en got %b exp 001", {pc_en, ifid_en, idex_bubble}); else nPass++;
    cyc();
    // hz_type stays at LU_CODE: it must be ignored while stalled
    nChecks++; if ({fwd_a_e, fwd_b_e} !== 4'b0000) $display("FAIL lu_c1_fwd got %b exp 0000", {fwd_a_e, fwd_b_e}); else nPass++;
    nChecks++; if ({pc_en, ifid_en, idex_bubble} !== 3'b110) $display("FAIL lu_c1_en got %b exp 110", {pc_en, ifid_en, idex_bubble}); else nPass++;
    cyc();
    nChecks++; if ({fwd_a_e, fwd_b_e} !== 4'b1000) $display("FAIL lu_c2_fwd got %b exp 1000", {fwd_a_e, fwd_b_e}); else nPass++;
    nChecks++; if (lu_cnt !== (PERF ? 4'd1 : 4'd0)) $display("FAIL lu_c2_cnt got %0d exp %0d", lu_cnt, PERF ? 1 : 0); else nPass++;
    nChecks++; if (pc_en !== 1'b0) $display("FAIL lu_b2b_pc got %b exp 0", pc_en); else nPass++;
    rt_e = 5'd7;
    cyc();
    cyc();
    nChecks++; if ({fwd_a_e, fwd_b_e} !== 4'b0010) $display("FAIL lu_b2b_fwd got %b exp 0010", {fwd_a_e, fwd_b_e}); else nPass++;
    nChecks++; if (lu_cnt !== (PERF ? 4'd2 : 4'd0)) $display("FAIL lu_b2b_cnt got %0d exp %0d", lu_cnt, PERF ? 2 : 0); else nPass++;
    hz_type = 6'b111111; rs_d = '0; rt_d = '0; rt_e = '0;
    cyc();
    cyc();
    nChecks++; if ({fwd_a_e, fwd_b_e} !== 4'b0000) $display("FAIL lu_zero_fwd got %b exp 0000", {fwd_a_e, fwd_b_e}); else nPass++;
  endtask

  task automatic test_priority();
    apply_reset();
    branch_taken_e = 1'b1; hz_type = 6'b111111;
    #1;
    nChecks++; if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b1011) $display("FAIL prio_br got %b exp 1011", {pc_en, ifid_en, ifid_flush, idex_bubble}); else nPass++;
    cyc();
    branch_taken_e = 1'b0; hz_type = 6'b000101;
    cyc();
    nChecks++; if ({fwd_a_e, fwd_b_e} !== 4'b0101) $display("FAIL prio_no_stall got %b exp 0101", {fwd_a_e, fwd_b_e}); else nPass++;
    mem_busy = 1'b1; branch_taken_e = 1'b1; hz_type = 6'b111111;
    #1;
    nChecks++; if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b0000) $display("FAIL prio_busy got %b exp 0000", {pc_en, ifid_en, ifid_flush, idex_bubble}); else nPass++;
    cyc();
    nChecks++; if ({fwd_a_e, fwd_b_e} !== 4'b0101) $display("FAIL prio_busy_hold got %b exp 0101", {fwd_a_e, fwd_b_e}); else nPass++;
    nChecks++; if ({lu_cnt, fl_cnt} !== (PERF ? 8'h01 : 8'h00)) $display("FAIL prio_cnt got %h exp %h", {lu_cnt, fl_cnt}, PERF ? 8'h01 : 8'h00); else nPass++;
    mem_busy = 1'b0; branch_taken_e = 1'b0; hz_type = '0;
  endtask

  task automatic test_mem_wait();
    apply_reset();
    hz_type = 6'b111111; rs_d = 5'd3; rt_d = 5'd3; rt_e = 5'd3;
    cyc();
    mem_busy = 1'b1; hz_type = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nChecks++; if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== 4'b0000) $display("FAIL wait_en%0d got %b exp 0000", i, {pc_en, ifid_en, ifid_flush, idex_bubble}); else nPass++;
      cyc();
      nChecks++; if ({fwd_a_e, fwd_b_e} !== 4'b0000) $display("FAIL wait_fwd%0d got %b exp 0000", i, {fwd_a_e, fwd_b_e}); else nPass++;
    end
    mem_busy = 1'b0;
    #1;
    nChecks++; if ({pc_en, ifid_en, idex_bubble} !== 3'b110) $display("FAIL wait_rel_en got %b exp 110", {pc_en, ifid_en, idex_bubble}); else nPass++;
    cyc();
    nChecks++; if ({fwd_a_e, fwd_b_e} !== 4'b1010) $display("FAIL wait_rel_fwd got %b exp 1010", {fwd_a_e, fwd_b_e}); else nPass++;
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    hz_type = 6'b111111; rs_d = 5'd4; rt_d = 5'd4; rt_e = 5'd4;
    cyc();
    rst_n = 1'b0;
    #1;
    hz_type = 6'b000101;
    rst_n = 1'b1;
    cyc();
    nChecks++; if ({fwd_a_e, fwd_b_e} !== 4'b0101) $display("FAIL rst_stall_fwd got %b exp 0101", {fwd_a_e, fwd_b_e}); else nPass++;
  endtask

  task automatic test_saturation();
    apply_reset();
    branch_taken_e = 1'b1;
    for (int i = 0; i < 17; i++) cyc();
    branch_taken_e = 1'b0;
    nChecks++; if (fl_cnt !== (PERF ? 4'd15 : 4'd0)) $display("FAIL sat_fl got %0d exp %0d", fl_cnt, PERF ? 15 : 0); else nPass++;
  endtask

  task automatic test_random();
    bit stalled = 0;
    bit hitA = 0, hitB = 0;
    int expA = 0, expB = 0, expLu = 0, expFl = 0;
    logic [3:0] expEn;
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      hz_type = ($urandom_range(0, 3) == 0) ? 6'b111111 : 6'($urandom_range(0, 62));
      rs_d = 5'($urandom_range(0, 3));
      rt_d = 5'($urandom_range(0, 3));
      rt_e = 5'($urandom_range(0, 3));
      branch_taken_e = ($urandom_range(0, 7) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      #1;
      if (mem_busy) expEn = 4'b0000;
      else if (stalled) expEn = 4'b1100;
      else if (branch_taken_e) expEn = 4'b1011;
      else if (hz_type == 6'b111111) expEn = 4'b0001;
      else expEn = 4'b1100;
      nChecks++; if ({pc_en, ifid_en, ifid_flush, idex_bubble} !== expEn) $display("FAIL rand_en@%0d got %b exp %b", i, {pc_en, ifid_en, ifid_flush, idex_bubble}, expEn); else nPass++;
      if (!mem_busy) begin
        if (stalled) begin
          expA = hitA ? 2 : 0; expB = hitB ? 2 : 0; stalled = 0;
        end else if (branch_taken_e) begin
          expA = 0; expB = 0; expFl = (expFl < 15) ? expFl + 1 : 15;
        end else if (hz_type == 6'b111111) begin
          expA = 0; expB = 0; stalled = 1;
          hitA = (rs_d == rt_e) && (rt_e != 0);
          hitB = (rt_d == rt_e) && (rt_e != 0);
          expLu = (expLu < 15) ? expLu + 1 : 15;
        end else begin
          expA = hz_type[3:2]; expB = hz_type[1:0];
        end
      end
      cyc();
      nChecks++; if ({fwd_a_e, fwd_b_e} !== {2'(expA), 2'(expB)}) $display("FAIL rand_fwd@%0d got %b exp %b", i, {fwd_a_e, fwd_b_e}, {2'(expA), 2'(expB)}); else nPass++;
      nChecks++; if ({lu_cnt, fl_cnt} !== (PERF ? {4'(expLu), 4'(expFl)} : 8'h00)) $display("FAIL rand_cnt@%0d got %h exp %h", i, {lu_cnt, fl_cnt}, PERF ? {4'(expLu), 4'(expFl)} : 8'h00); else nPass++;
    end
    mem_busy = 1'b0; branch_taken_e = 1'b0; hz_type = '0;
  endtask

  initial begin
    #2;
    test_reset();
    test_forwarding();
    test_load_use();
    test_priority();
    test_mem_wait();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline-control stage directly downstream of the D/E dependency detector.
- Consumes the 6-bit hazard code for the D/E instruction pair and produces PC/IF-ID enables, IF-ID flush and ID-EX bubble.
- Produces the forwarding selects registered into ID/EX, so they reach EX together with their instruction.
- Resolves load-use hazards with one stall cycle followed by distance-2 forwarding; also handles taken-branch flush and data-memory wait.

Parameters:
- CNT_W, 16, width of the optional performance counters.
- LU_CODE, 6'b111111, hazard code meaning load-use conflict.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hz_type  in  6  detector code: [3:2] operand-A select, [1:0] operand-B select; LU_CODE means load-use.
- rs_d  in  5  rs field of the D-stage instruction.
- rt_d  in  5  rt field of the D-stage instruction.
- rt_e  in  5  rt field of the E-stage instruction (load destination).
- branch_taken_e  in  1  branch resolved taken in E.
- mem_busy  in  1  data memory not ready; freezes the whole pipeline.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load NOP into ID/EX.
- fwd_a_e  out  2  registered operand-A forward select for EX.
- fwd_b_e  out  2  registered operand-B forward select for EX.
- lu_cnt  out  CNT_W  load-use stall count (optional feature).
- fl_cnt  out  CNT_W  branch flush count (optional feature).

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n), and applies to every flop.
- While rst_n=0: state=RUN, fwd_a_e=fwd_b_e=00, mask=00, counters=0, pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1.
- Output timing: pc_en, ifid_en, ifid_flush and idex_bubble are combinational from state and inputs. fwd_* are registered and take effect one cycle after the decision.
- Priority: mem_busy > branch_taken_e > load-use > normal.
- mem_busy=1, any state:
  - pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0.
  - State, mask, fwd_* and counters hold.
- RUN, branch_taken_e=1:
  - pc_en=1, ifid_en=0, ifid_flush=1, idex_bubble=1.
  - fwd_*<=00; stay RUN.
- RUN, hz_type==LU_CODE:
  - pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1.
  - fwd_*<=00; mask[1]<=(rs_d==rt_e), mask[0]<=(rt_d==rt_e).
  - Next state LU_STALL.
- RUN, otherwise:
  - pc_en=1, ifid_en=1, flush=0, bubble=0.
  - fwd_a_e<=hz_type[3:2], fwd_b_e<=hz_type[1:0].
- LU_STALL (E holds a bubble, the load is in M):
  - hz_type and branch_taken_e are ignored.
  - pc_en=1, ifid_en=1, flush=0, bubble=0.
  - fwd_a_e<=mask[1]?10:00, fwd_b_e<=mask[0]?10:00 (10 = forward from M/WB).
  - mask<=00; next state RUN.
- Back-to-back load-use: permitted. The first RUN cycle after LU_STALL evaluates a fresh hz_type normally.
- Register $zero: rs/rt/rt_e equal to 0 never set a mask bit.
- Reset asserted mid-LU_STALL: returns to RUN immediately; the pending mask is discarded.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - lu_cnt increments once per load-use detection (the RUN->LU_STALL transition).
  - fl_cnt increments once per branch flush cycle.
  - Both counters saturate at all-ones, do not count while mem_busy=1, and clear on reset.
- Undefined: lu_cnt and fl_cnt are constant 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 mid-run -> pc_en=0, ifid_flush=1, idex_bubble=1, fwd=00 immediately; after release with hz_type=0 -> pc_en=1, ifid_en=1.
- Forwarding: RUN, hz_type=6'b000101 -> next cycle fwd_a_e=01, fwd_b_e=01. hz_type=6'b000111 -> fwd_a_e=01, fwd_b_e=11.
- Load-use:
  - Stimulus: hz_type=111111, rs_d=5, rt_d=7, rt_e=5.
  - Cycle 0: pc_en=0, idex_bubble=1.
  - Cycle 1: state LU_STALL, fwd=00, pc_en=1.
  - Cycle 2: fwd_a_e=10, fwd_b_e=00; lu_cnt=1 with the macro.
- Priority: branch_taken_e=1 and hz_type=111111 together -> flush path (ifid_flush=1, pc_en=1), no LU_STALL. Adding mem_busy=1 -> all enables 0, nothing changes.
- Memory wait in stall: mem_busy=1 for 3 cycles while in LU_STALL -> state and mask held. Cycle after release -> fwd=10 on the conflicting operand.
- Saturation (macro defined, CNT_W=4): 17 flushes -> fl_cnt=15.
